// File: rtl/exec_mpadc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exec_mpadc_ctrl_pkg                                          |
// | Description : Shared widths, flag bit positions and FSM state encodings    |
// |               for the multi-word add/subtract controller.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package exec_mpadc_ctrl_pkg;

  localparam int c_opr_width   = 16;  // operand word width
  localparam int c_flags_width = 4;   // flag vector {V,S,Z,C}

  // Flag bit positions inside the flag vector
  localparam int c_flag_c = 0;
  localparam int c_flag_z = 1;
  localparam int c_flag_s = 2;
  localparam int c_flag_v = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/exec_mpadc_ctrl_adcx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exec_adcx                                                    |
// | Description : One-word add/subtract-with-carry datapath.                   |
// |               The incoming carry flag is a borrow when subtracting; the    |
// |               outgoing carry is the raw adder carry (1 = no borrow).       |
// | Ports       : a_i, b_i   operands          minus_i  1 = a - b             |
// |               cf_i       carry/borrow flag res_o    result word           |
// |               carry_o, zero_o, sign_o, ovf_o        result flags           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exec_adcx
  import exec_mpadc_ctrl_pkg::*;
#(
  parameter int W = c_opr_width
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         minus_i,
  input  logic         cf_i,
  output logic [W-1:0] res_o,
  output logic         carry_o,
  output logic         zero_o,
  output logic         sign_o,
  output logic         ovf_o
);

  logic [W-1:0] w_b_eff;
  logic         w_cin;
  logic [W:0]   w_sum;

  // Subtraction is a + ~b + ~borrow, so the adder carry-in is flag XOR minus.
  always_comb begin
    w_b_eff = minus_i ? ~b_i : b_i;
    w_cin   = cf_i ^ minus_i;
    w_sum   = {1'b0, a_i} + {1'b0, w_b_eff} + {{W{1'b0}}, w_cin};
  end

  assign res_o   = w_sum[W-1:0];
  assign carry_o = w_sum[W];
  assign zero_o  = (w_sum[W-1:0] == '0);
  assign sign_o  = w_sum[W-1];
  assign ovf_o   = (a_i[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != a_i[W-1]);

endmodule
`default_nettype wire

// File: rtl/exec_mpadc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exec_mpadc_ctrl                                              |
// | Description : Multi-word add/subtract sequencer. Reads one word of each    |
// |               operand per RD cycle, computes and writes one result word    |
// |               per EX cycle, chaining carry and accumulating zero.          |
// | Ports       : clk_i, rst_n_i          clock, async active-low reset        |
// |               start_i, minus_i, use_carry_i, flags_i, len_i, base*_i       |
// |                                       operation request (sampled in IDLE) |
// |               abort_i                 cancel operation in RD/EX            |
// |               rd_en_o, rd_addr0/1_o, rd_data0/1_i   operand read port      |
// |               wr_en_o, wr_addr_o, wr_data_o         result write port      |
// |               busy_o, done_o, flags_o               status                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exec_mpadc_ctrl
  import exec_mpadc_ctrl_pkg::*;
#(
  parameter int W_OPR   = c_opr_width,
  parameter int W_FLAGS = c_flags_width,
  parameter int W_ADDR  = 8,
  parameter int W_LEN   = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               minus_i,
  input  logic               use_carry_i,
  input  logic [W_FLAGS-1:0] flags_i,
  input  logic [W_LEN-1:0]   len_i,
  input  logic [W_ADDR-1:0]  base0_i,
  input  logic [W_ADDR-1:0]  base1_i,
  input  logic [W_ADDR-1:0]  based_i,
  input  logic               abort_i,
  output logic               rd_en_o,
  output logic [W_ADDR-1:0]  rd_addr0_o,
  output logic [W_ADDR-1:0]  rd_addr1_o,
  input  logic [W_OPR-1:0]   rd_data0_i,
  input  logic [W_OPR-1:0]   rd_data1_i,
  output logic               wr_en_o,
  output logic [W_ADDR-1:0]  wr_addr_o,
  output logic [W_OPR-1:0]   wr_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [W_FLAGS-1:0] flags_o
);

  localparam logic [W_LEN-1:0] c_one_len = W_LEN'(1);

  state_e             state_q, state_d;
  logic [W_LEN-1:0]   k_q, k_d;
  logic [W_LEN-1:0]   len_q, len_d;
  logic [W_ADDR-1:0]  base0_q, base0_d;
  logic [W_ADDR-1:0]  base1_q, base1_d;
  logic [W_ADDR-1:0]  based_q, based_d;
  logic               minus_q, minus_d;
  logic               cf_q, cf_d;        // carry/borrow flag for the current word
  logic               zacc_q, zacc_d;    // AND of zero over words done so far
  logic [W_FLAGS-1:0] fpend_q, fpend_d;  // flags to publish when leaving DONE
  logic [W_FLAGS-1:0] flags_q, flags_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [W_OPR-1:0]   w_res;
  logic               w_carry;
  logic               w_zero;
  logic               w_sign;
  logic               w_ovf;

  exec_adcx #(
    .W (W_OPR)
  ) u_adcx (
    .a_i     (rd_data0_i),
    .b_i     (rd_data1_i),
    .minus_i (minus_q),
    .cf_i    (cf_q),
    .res_o   (w_res),
    .carry_o (w_carry),
    .zero_o  (w_zero),
    .sign_o  (w_sign),
    .ovf_o   (w_ovf)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    base0_d = base0_q;
    base1_d = base1_q;
    based_d = based_q;
    minus_d = minus_q;
    cf_d    = cf_q;
    zacc_d  = zacc_q;
    fpend_d = fpend_q;
    flags_d = flags_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          base0_d = base0_i;
          base1_d = base1_i;
          based_d = based_i;
          minus_d = minus_i;
          cf_d    = use_carry_i & flags_i[c_flag_c];
          k_d     = '0;
          zacc_d  = 1'b1;
          // A zero-length operation simply returns the incoming flags.
          fpend_d = flags_i;
          state_d = (len_i == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        state_d = abort_i ? ST_IDLE : ST_EX;
      end
      ST_EX: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          cf_d   = w_carry ^ minus_q;
          zacc_d = zacc_q & w_zero;
          if (k_q == len_q - c_one_len) begin
            fpend_d           = '0;
            fpend_d[c_flag_c] = w_carry;
            fpend_d[c_flag_z] = zacc_q & w_zero;
            fpend_d[c_flag_s] = w_sign;
            fpend_d[c_flag_v] = w_ovf;
            state_d           = ST_DONE;
          end else begin
            k_d     = k_q + c_one_len;
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        flags_d = fpend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered so they line up exactly with the state they belong to.
    rd_en_d = (state_d == ST_RD);
    wr_en_d = (state_d == ST_EX);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      base0_q <= '0;
      base1_q <= '0;
      based_q <= '0;
      minus_q <= 1'b0;
      cf_q    <= 1'b0;
      zacc_q  <= 1'b0;
      fpend_q <= '0;
      flags_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      base0_q <= base0_d;
      base1_q <= base1_d;
      based_q <= based_d;
      minus_q <= minus_d;
      cf_q    <= cf_d;
      zacc_q  <= zacc_d;
      fpend_q <= fpend_d;
      flags_q <= flags_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Addresses come straight from reset-cleared registers, so they are 0 in reset.
  assign rd_addr0_o = base0_q + W_ADDR'(k_q);
  assign rd_addr1_o = base1_q + W_ADDR'(k_q);
  assign wr_addr_o  = based_q + W_ADDR'(k_q);

  // Abort kills the write in the very cycle it is raised.
  assign wr_en_o    = wr_en_q & ~abort_i;
  // Data is gated so the port stays 0 outside EX and during reset.
  assign wr_data_o  = wr_en_q ? w_res : '0;

  assign rd_en_o    = rd_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign flags_o    = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_mpadc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_exec_mpadc_ctrl                                           |
// | Description : Directed self-checking bench for exec_mpadc_ctrl with a      |
// |               small operand/result memory model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_exec_mpadc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        minus_i = 1'b0;
  logic        use_carry_i = 1'b0;
  logic [3:0]  flags_i = '0;
  logic [3:0]  len_i = '0;
  logic [7:0]  base0_i = '0;
  logic [7:0]  base1_i = '0;
  logic [7:0]  based_i = '0;
  logic        abort_i = 1'b0;
  logic        rd_en_o;
  logic [7:0]  rd_addr0_o;
  logic [7:0]  rd_addr1_o;
  logic [15:0] rd_data0_i = '0;
  logic [15:0] rd_data1_i = '0;
  logic        wr_en_o;
  logic [7:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  flags_o;

  exec_mpadc_ctrl #(
    .W_OPR   (16),
    .W_FLAGS (4),
    .W_ADDR  (8),
    .W_LEN   (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .minus_i     (minus_i),
    .use_carry_i (use_carry_i),
    .flags_i     (flags_i),
    .len_i       (len_i),
    .base0_i     (base0_i),
    .base1_i     (base1_i),
    .based_i     (based_i),
    .abort_i     (abort_i),
    .rd_en_o     (rd_en_o),
    .rd_addr0_o  (rd_addr0_o),
    .rd_addr1_o  (rd_addr1_o),
    .rd_data0_i  (rd_data0_i),
    .rd_data1_i  (rd_data1_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .flags_o     (flags_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: read data appears the cycle after the read strobe.
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [7:0]  wa [$];
  logic [15:0] wd [$];
  int n_rd = 0, n_wr = 0, n_done = 0, n_overlap = 0;

  always @(posedge clk_i) begin
    if (rd_en_o) begin
      rd_data0_i <= mem0[rd_addr0_o];
      rd_data1_i <= mem1[rd_addr1_o];
      n_rd       <= n_rd + 1;
    end
    if (wr_en_o) begin
      wa.push_back(wr_addr_o);
      wd.push_back(wr_data_o);
      n_wr <= n_wr + 1;
    end
    if (done_o) n_done <= n_done + 1;
    if (rd_en_o && wr_en_o) n_overlap <= n_overlap + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] wrec(input int i);
    if (i < wa.size()) return {wa[i], wd[i]};
    return 'x;
  endfunction

  // Results of the last op() call
  int   lat, d_rd, d_wr, d_done, wbase;
  logic busy1, busy_at_done, wr_pre, wr_ab;

  task automatic kick(input logic [3:0] len, input logic minus, input logic uc,
                      input logic [3:0] fl, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] bd);
    @(negedge clk_i);
    start_i = 1'b1; len_i = len; minus_i = minus; use_carry_i = uc; flags_i = fl;
    base0_i = b0; base1_i = b1; based_i = bd;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic op(input logic [3:0] len, input logic minus, input logic uc,
                    input logic [3:0] fl, input logic [7:0] b0, input logic [7:0] b1,
                    input logic [7:0] bd, input int abort_at, input bit poke);
    int rd0, wr0, dn0;
    rd0 = n_rd; wr0 = n_wr; dn0 = n_done; wbase = wa.size();
    lat = 0; busy1 = 1'b0; busy_at_done = 1'b1; wr_pre = 1'b0; wr_ab = 1'b1;
    kick(len, minus, uc, fl, b0, b1, bd);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      if (c == 1) busy1 = busy_o;
      if (done_o && lat == 0) begin
        lat = c;
        busy_at_done = busy_o;
      end
      if (poke && c == 1) begin
        start_i = 1'b1; len_i = 4'd0; base0_i = 8'hC0; based_i = 8'hC0;
      end
      if (c == abort_at) begin
        wr_pre  = wr_en_o;
        abort_i = 1'b1;
        #1 wr_ab = wr_en_o;
      end
    end
    d_rd = n_rd - rd0; d_wr = n_wr - wr0; d_done = n_done - dn0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_ctl", {busy_o, done_o, rd_en_o, wr_en_o}, 4'b0000);
    check("rst_flags", flags_o, 4'h0);
    check("rst_addr", {rd_addr0_o, rd_addr1_o, wr_addr_o}, 24'h0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    // Add, len=2: 0x0001_FFFF + 0x0000_0001; stray flags_i ignored without use_carry
    mem0[8'h10] = 16'hFFFF; mem0[8'h11] = 16'h0001;
    mem1[8'h20] = 16'h0001; mem1[8'h21] = 16'h0000;
    op(4'd2, 1'b0, 1'b0, 4'b1111, 8'h10, 8'h20, 8'h30, 0, 1'b0);
    check("add2_lat", lat, 5);
    check("add2_flags", flags_o, 4'b0000);
    check("add2_nwr", d_wr, 2);
    check("add2_nrd", d_rd, 2);
    check("add2_ndone", d_done, 1);
    check("add2_w0", wrec(wbase), {8'h30, 16'h0000});
    check("add2_w1", wrec(wbase + 1), {8'h31, 16'h0002});
    check("add2_busy", {busy1, busy_at_done}, 2'b10);

    // Subtract, len=2: 0x0001_0000 - 0x0000_0001 = 0x0000_FFFF, no final borrow
    mem0[8'h40] = 16'h0000; mem0[8'h41] = 16'h0001;
    mem1[8'h50] = 16'h0001; mem1[8'h51] = 16'h0000;
    op(4'd2, 1'b1, 1'b0, 4'b0000, 8'h40, 8'h50, 8'h60, 0, 1'b0);
    check("sub2_lat", lat, 5);
    check("sub2_flags", flags_o, 4'b0001);
    check("sub2_w0", wrec(wbase), {8'h60, 16'hFFFF});
    check("sub2_w1", wrec(wbase + 1), {8'h61, 16'h0000});

    // Subtract, len=3, equal operands, all addresses wrap past 0xFF
    mem0[8'hFE] = 16'h9ABC; mem0[8'hFF] = 16'h5678; mem0[8'h00] = 16'h1234;
    mem1[8'hFE] = 16'h9ABC; mem1[8'hFF] = 16'h5678; mem1[8'h00] = 16'h1234;
    op(4'd3, 1'b1, 1'b0, 4'b0000, 8'hFE, 8'hFE, 8'hFE, 0, 1'b0);
    check("sub3_lat", lat, 7);
    check("sub3_flags", flags_o, 4'b0011);
    check("sub3_nwr", d_wr, 3);
    check("sub3_w0", wrec(wbase), {8'hFE, 16'h0000});
    check("sub3_w1", wrec(wbase + 1), {8'hFF, 16'h0000});
    check("sub3_w2", wrec(wbase + 2), {8'h00, 16'h0000});

    // len=1 add with carry-in: 0x7FFF + 0 + 1 = 0x8000, signed overflow
    mem0[8'h70] = 16'h7FFF; mem1[8'h70] = 16'h0000;
    op(4'd1, 1'b0, 1'b1, 4'b0001, 8'h70, 8'h70, 8'h71, 0, 1'b0);
    check("adc1_lat", lat, 3);
    check("adc1_flags", flags_o, 4'b1100);
    check("adc1_w0", wrec(wbase), {8'h71, 16'h8000});

    // len=1 subtract with borrow-in: 5 - 3 - 1 = 1, no borrow out
    mem0[8'h80] = 16'h0005; mem1[8'h80] = 16'h0003;
    op(4'd1, 1'b1, 1'b1, 4'b0001, 8'h80, 8'h80, 8'h81, 0, 1'b0);
    check("sbb1_flags", flags_o, 4'b0001);
    check("sbb1_w0", wrec(wbase), {8'h81, 16'h0001});

    // start_i while busy is ignored
    op(4'd2, 1'b0, 1'b0, 4'b0000, 8'h10, 8'h20, 8'h32, 0, 1'b1);
    check("poke_lat", lat, 5);
    check("poke_ndone", d_done, 1);
    check("poke_nwr", d_wr, 2);
    check("poke_w0", wrec(wbase), {8'h32, 16'h0000});
    check("poke_w1", wrec(wbase + 1), {8'h33, 16'h0002});

    // len=0: immediate done, flags pass through, no memory traffic
    op(4'd0, 1'b1, 1'b1, 4'b1010, 8'h10, 8'h20, 8'h90, 0, 1'b0);
    check("len0_lat", lat, 1);
    check("len0_flags", flags_o, 4'b1010);
    check("len0_traffic", {d_rd[7:0], d_wr[7:0]}, 16'h0000);

    // Abort in EX of word 1: word 0 written, word 1 suppressed, no done
    op(4'd2, 1'b0, 1'b0, 4'b0000, 8'h10, 8'h20, 8'h34, 3, 1'b0);
    check("abort_wr_gate", {wr_pre, wr_ab}, 2'b10);
    check("abort_ndone", d_done, 0);
    check("abort_nwr", d_wr, 1);
    check("abort_w0", wrec(wbase), {8'h34, 16'h0000});
    check("abort_flags", flags_o, 4'b1010);
    check("abort_busy", busy_o, 1'b0);

    // Asynchronous reset while in RD
    kick(4'd2, 1'b0, 1'b0, 4'b0000, 8'h10, 8'h20, 8'h36);
    check("rstmid_pre_rd", rd_en_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rstmid_ctl", {busy_o, done_o, rd_en_o, wr_en_o}, 4'b0000);
    check("rstmid_flags", flags_o, 4'h0);
    check("rstmid_addr", {rd_addr0_o, rd_addr1_o, wr_addr_o}, 24'h0);
    check("rstmid_wdata", wr_data_o, 16'h0);
    begin
      int rd0, wr0, dn0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      rd0 = n_rd; wr0 = n_wr; dn0 = n_done;
      repeat (10) @(posedge clk_i);
      #1;
      check("rstmid_quiet", {n_rd - rd0, n_wr - wr0, n_done - dn0}, 0);
      check("rstmid_busy", busy_o, 1'b0);
    end

    check("rd_wr_overlap", n_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
